// File: rtl/rf_wb_ctrl_if.sv
// Write-back request bus between the execute/memory requesters and rf_wb_ctrl.
// Index 0 = ALU, 1 = load unit, 2 = CSR/debug.
interface rf_wb_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [2:0]    req;
    logic [AW-1:0] req_addr0;
    logic [AW-1:0] req_addr1;
    logic [AW-1:0] req_addr2;
    logic [DW-1:0] req_data0;
    logic [DW-1:0] req_data1;
    logic [DW-1:0] req_data2;
    logic [2:0]    ack;

    modport master (
        output req, req_addr0, req_addr1, req_addr2,
        output req_data0, req_data1, req_data2,
        input  ack
    );

    modport slave (
        input  req, req_addr0, req_addr1, req_addr2,
        input  req_data0, req_data1, req_data2,
        output ack
    );
endinterface

// File: rtl/rf_wb_ctrl.sv
// Register-file write-back arbiter (3-way round-robin) with a pending-write
// scoreboard that the issue stage uses for RAW/WAW hazard detection.
module rf_wb_ctrl #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic              clk,
    input  logic              rstn,
    rf_wb_ctrl_if.slave       wb,
    output logic              rf_we,
    output logic [AW-1:0]     rf_wa,
    output logic [DW-1:0]     rf_wd,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    output logic              iss_stall,
    input  logic [AW-1:0]     chk_ra0,
    input  logic [AW-1:0]     chk_ra1,
    output logic              hz0,
    output logic              hz1,
    output logic [(1<<AW)-1:0] pend
);
    localparam int NR = 1 << AW;

    logic [1:0]    last;
    logic [1:0]    cand1;
    logic [1:0]    cand2;
    logic [1:0]    gnt_idx;
    logic          gnt_vld;
    logic [2:0]    elig;
    logic [2:0]    ack_q;
    logic [AW-1:0] gnt_addr;
    logic [DW-1:0] gnt_data;
    logic          pend_set;
    logic [NR-1:0] pend_next;

    function automatic logic [1:0] rr_next(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // A requester whose ack is high this cycle is about to drop/replace its
    // request, so it must not be granted a second time on this edge.
    always_comb begin
        elig    = wb.req & ~ack_q;
        cand1   = rr_next(last);
        cand2   = rr_next(cand1);
        gnt_vld = 1'b1;
        gnt_idx = last;
        if (elig[cand1]) begin
            gnt_idx = cand1;
        end else if (elig[cand2]) begin
            gnt_idx = cand2;
        end else if (elig[last]) begin
            gnt_idx = last;
        end else begin
            gnt_vld = 1'b0;
        end
    end

    always_comb begin
        gnt_addr = wb.req_addr2;
        gnt_data = wb.req_data2;
        case (gnt_idx)
            2'd0: begin
                gnt_addr = wb.req_addr0;
                gnt_data = wb.req_data0;
            end
            2'd1: begin
                gnt_addr = wb.req_addr1;
                gnt_data = wb.req_data1;
            end
            default: begin
                gnt_addr = wb.req_addr2;
                gnt_data = wb.req_data2;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack_q <= '0;
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
            last  <= 2'd2;
        end else begin
            ack_q <= gnt_vld ? (3'b001 << gnt_idx) : 3'b000;
            rf_we <= gnt_vld & (gnt_addr != '0);
            if (gnt_vld) begin
                rf_wa <= gnt_addr;
                rf_wd <= gnt_data;
                last  <= gnt_idx;
            end
        end
    end

    assign wb.ack = ack_q;

    assign iss_stall = iss_valid & pend[iss_rd];
    assign hz0       = pend[chk_ra0];
    assign hz1       = pend[chk_ra1];

    // Set after clear: a freshly issued producer must stay pending even if an
    // older write to the same register is committing right now.
    always_comb begin
        pend_set  = iss_valid & ~iss_stall & (iss_rd != '0);
        pend_next = pend;
        if (rf_we) begin
            pend_next[rf_wa] = 1'b0;
        end
        if (pend_set) begin
            pend_next[iss_rd] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed bench for rf_wb_ctrl: queue-driven requesters, a cycle-level model of
// the arbitration/scoreboard rules, a simple RF image, and literal spot checks.
module tb_rf_wb_ctrl;
    logic        clk = 1'b0;
    logic        rstn;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_stall;
    logic [4:0]  chk_ra0;
    logic [4:0]  chk_ra1;
    logic        hz0;
    logic        hz1;
    logic [31:0] pend;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    rf_wb_ctrl_if #(.DW(32), .AW(5)) bus ();

    rf_wb_ctrl #(.DW(32), .AW(5)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .wb        (bus.slave),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_stall (iss_stall),
        .chk_ra0   (chk_ra0),
        .chk_ra1   (chk_ra1),
        .hz0       (hz0),
        .hz1       (hz1),
        .pend      (pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-requester work queues; a requester pops its head on seeing its ack.
    logic [4:0]  fa [3][16];
    logic [31:0] fd [3][16];
    int hd [3];
    int tl [3];

    task automatic push(input int i, input logic [4:0] a, input logic [31:0] d);
        fa[i][tl[i] % 16] = a;
        fd[i][tl[i] % 16] = d;
        tl[i]++;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        bus.req       = 3'b000;
        bus.req_addr0 = '0;
        bus.req_addr1 = '0;
        bus.req_addr2 = '0;
        bus.req_data0 = '0;
        bus.req_data1 = '0;
        bus.req_data2 = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (bus.ack[i] && hd[i] != tl[i]) hd[i]++;
            end
            bus.req[0]    = (hd[0] != tl[0]);
            bus.req[1]    = (hd[1] != tl[1]);
            bus.req[2]    = (hd[2] != tl[2]);
            bus.req_addr0 = fa[0][hd[0] % 16];
            bus.req_data0 = fd[0][hd[0] % 16];
            bus.req_addr1 = fa[1][hd[1] % 16];
            bus.req_data1 = fd[1][hd[1] % 16];
            bus.req_addr2 = fa[2][hd[2] % 16];
            bus.req_data2 = fd[2][hd[2] % 16];
        end
    end

    // Register file image, committed on the falling edge like the real RF.
    logic [31:0] rf_mem [32];
    always @(negedge clk) begin
        if (rf_we === 1'b1) rf_mem[rf_wa] = rf_wd;
    end

    // Behavioural model: round-robin search from the last grant, pending mask as a bit set.
    int          m_last;
    int          m_g;
    int          m_c;
    logic [2:0]  m_ack;
    logic [2:0]  m_elig;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic [31:0] m_pend;
    logic [31:0] m_np;

    function automatic logic [4:0] addr_of(input int g);
        return (g == 0) ? bus.req_addr0 : (g == 1) ? bus.req_addr1 : bus.req_addr2;
    endfunction

    function automatic logic [31:0] data_of(input int g);
        return (g == 0) ? bus.req_data0 : (g == 1) ? bus.req_data1 : bus.req_data2;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_last = 2;
            m_ack  = 3'b000;
            m_we   = 1'b0;
            m_wa   = '0;
            m_wd   = '0;
            m_pend = '0;
        end else begin
            m_elig = bus.req & ~m_ack;
            m_g    = -1;
            for (int k = 1; k <= 3; k++) begin
                m_c = (m_last + k) % 3;
                if (m_g < 0 && m_elig[m_c[1:0]]) m_g = m_c;
            end
            m_np = m_pend;
            if (m_we) m_np[m_wa] = 1'b0;
            if (iss_valid && !m_pend[iss_rd] && iss_rd != 5'd0) m_np[iss_rd] = 1'b1;
            m_pend = m_np;
            if (m_g >= 0) begin
                m_ack  = 3'b001 << m_g;
                m_last = m_g;
                m_wa   = addr_of(m_g);
                m_wd   = data_of(m_g);
                m_we   = (m_wa != 5'd0);
            end else begin
                m_ack = 3'b000;
                m_we  = 1'b0;
            end
        end
    end

    int glog [16];
    int glog_n = 0;

    always @(posedge clk) begin
        #1;
        if (rstn && started) begin
            chk("ack", {29'd0, bus.ack}, {29'd0, m_ack});
            chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
            chk("rf_wa", {27'd0, rf_wa}, {27'd0, m_wa});
            chk("rf_wd", rf_wd, m_wd);
            chk("pend", pend, m_pend);
            chk("iss_stall", {31'd0, iss_stall}, {31'd0, iss_valid & m_pend[iss_rd]});
            chk("hz0", {31'd0, hz0}, {31'd0, m_pend[chk_ra0]});
            chk("hz1", {31'd0, hz1}, {31'd0, m_pend[chk_ra1]});
            if (bus.ack != 3'b000 && glog_n < 16) begin
                glog[glog_n] = bus.ack[0] ? 0 : bus.ack[1] ? 1 : 2;
                glog_n++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int exp_order [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = '0;
        rstn      = 1'b0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        chk_ra0   = '0;
        chk_ra1   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pend", pend, 32'h0);
        chk("reset_we", {31'd0, rf_we}, 32'd0);
        @(negedge clk);
        rstn    = 1'b1;
        started = 1'b1;

        // single write from the ALU
        @(posedge clk); #2;
        push(0, 5'd5, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("single_ack", {29'd0, bus.ack}, 32'd1);
        chk("single_we", {31'd0, rf_we}, 32'd1);
        chk("single_wa", {27'd0, rf_wa}, 32'd5);
        chk("single_wd", rf_wd, 32'hDEAD_BEEF);

        // write to x0 from the load unit
        @(posedge clk); #2;
        push(1, 5'd0, 32'h0000_1234);
        @(posedge clk); #1;
        chk("x0_ack", {29'd0, bus.ack}, 32'd2);
        chk("x0_we", {31'd0, rf_we}, 32'd0);
        chk("x0_wd", rf_wd, 32'h0000_1234);

        // scoreboard: issue, re-issue, write-back
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd7; chk_ra0 = 5'd7;
        @(negedge clk);
        iss_valid = 1'b0;
        #1;
        chk("sb_pend7", {31'd0, pend[7]}, 32'd1);
        chk("sb_hz0", {31'd0, hz0}, 32'd1);
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd7;
        #1;
        chk("sb_stall", {31'd0, iss_stall}, 32'd1);
        @(negedge clk);
        iss_valid = 1'b0;
        #1;
        chk("sb_pend_unchanged", pend, 32'h0000_0080);
        @(posedge clk); #2;
        push(0, 5'd7, 32'h7777_0007);
        @(posedge clk); #1;
        chk("sb_wb_we", {31'd0, rf_we}, 32'd1);
        chk("sb_wb_wa", {27'd0, rf_wa}, 32'd7);
        chk("sb_pend7_held", {31'd0, pend[7]}, 32'd1);
        @(posedge clk); #1;
        chk("sb_pend7_clear", {31'd0, pend[7]}, 32'd0);
        chk("sb_hz0_clear", {31'd0, hz0}, 32'd0);

        // same-cycle clear and set of x9
        @(posedge clk); #2;
        chk("ss_pre_pend9", {31'd0, pend[9]}, 32'd0);
        push(1, 5'd9, 32'h0000_9999);
        @(posedge clk); #1;
        chk("ss_we", {31'd0, rf_we}, 32'd1);
        chk("ss_wa", {27'd0, rf_wa}, 32'd9);
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd9; chk_ra1 = 5'd9;
        @(posedge clk); #1;
        chk("ss_pend9", {31'd0, pend[9]}, 32'd1);
        chk("ss_hz1", {31'd0, hz1}, 32'd1);
        @(negedge clk);
        iss_rd = 5'd12;
        @(negedge clk);
        iss_valid = 1'b0;

        // asynchronous reset mid-cycle with all three requesting, then round-robin
        @(posedge clk); #2;
        push(0, 5'd3,  32'hA000_0003);
        push(1, 5'd4,  32'hB000_0004);
        push(2, 5'd6,  32'hC000_0006);
        push(0, 5'd10, 32'hA000_000A);
        push(1, 5'd11, 32'hB000_000B);
        push(2, 5'd13, 32'hC000_000D);
        @(negedge clk); #2;
        chk("pre_reset_pend12", {31'd0, pend[12]}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("async_ack", {29'd0, bus.ack}, 32'd0);
        chk("async_we", {31'd0, rf_we}, 32'd0);
        chk("async_pend", pend, 32'd0);
        glog_n = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        chk("rr_count", glog_n, 32'd6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rr_order_%0d", k), glog[k], exp_order[k]);
        end

        chk("rf_x5", rf_mem[5], 32'hDEAD_BEEF);
        chk("rf_x0", rf_mem[0], 32'h0);
        chk("rf_x7", rf_mem[7], 32'h7777_0007);
        chk("rf_x13", rf_mem[13], 32'hC000_000D);

        repeat (2) @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
